// File: rtl/qam_slicer.sv
`timescale 1ns/1ps
// qam_slicer: two-stage pipelined hard-decision slicer for square QAM with float32 I/Q.
// Each axis snaps to the nearest odd PAM level and emits a Gray label; clipped components are counted.
module qam_slicer #(
  parameter int B     = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_i,
  input  logic [31:0]      in_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_i,
  output logic [31:0]      out_q,
  output logic [2*B-1:0]   out_label,
  output logic [CNT_W-1:0] clip_cnt,
  input  logic             cnt_clr
);
  localparam int         SW      = CNT_W + 1;
  localparam logic [7:0] SAT_EXP = 8'(127 + B);
  localparam logic [2:0] K       = 3'((1 << (B - 1)) - 1);

  typedef struct packed {
    logic       sign;
    logic [2:0] k;
  } comp_t;

  // hi = {sign, exponent, three leading mantissa bits}; lower mantissa bits never move k.
  function automatic comp_t decode(input logic [11:0] hi);
    comp_t      r;
    logic [7:0] e;
    logic [7:0] sh;
    logic [3:0] top;
    e      = hi[10:3];
    top    = {1'b1, hi[2:0]};
    sh     = e - 8'd127;
    r.sign = hi[11];
    r.k    = 3'd0;
    if (e >= SAT_EXP) r.k = K;
    else if (e >= 8'd128) r.k = 3'(top >> (8'd4 - sh));
    return r;
  endfunction

  function automatic logic [31:0] level(input comp_t c);
    logic [3:0]  l;
    logic [31:0] f;
    l = {c.k, 1'b1};
    f = {c.sign, 8'd127, 23'd0};
    if (l[3])      f = {c.sign, 8'd130, l[2:0], 20'd0};
    else if (l[2]) f = {c.sign, 8'd129, l[1:0], 21'd0};
    else if (l[1]) f = {c.sign, 8'd128, l[0], 22'd0};
    return f;
  endfunction

  function automatic logic [B-1:0] gray(input comp_t c);
    logic [B-1:0] n;
    n = c.sign ? (B'(K) - B'(c.k)) : (B'(K) + B'(1) + B'(c.k));
    return n ^ (n >> 1);
  endfunction

  comp_t          dec_i, dec_q, s1_i, s1_q;
  logic           s1_full, s2_full, s1_load, s2_load;
  logic           clip_i, clip_q;
  logic [1:0]     clip_inc;
  logic [SW-1:0]  clip_sum;
  logic           unused_mant;

  assign unused_mant = ^{in_i[19:0], in_q[19:0]};

  assign dec_i    = decode(in_i[31:20]);
  assign dec_q    = decode(in_q[31:20]);
  assign clip_i   = in_i[30:23] >= SAT_EXP;
  assign clip_q   = in_q[30:23] >= SAT_EXP;
  assign clip_inc = {1'b0, clip_i} + {1'b0, clip_q};
  assign clip_sum = {1'b0, clip_cnt} + SW'(clip_inc);

  // valid/ready: a beat moves when valid & ready are both high on a rising edge; a holding
  // stage keeps its data stable until taken, and a stage loads when empty or draining that cycle.
  assign out_valid = s2_full;
  assign s2_load   = s1_full & (!s2_full | out_ready);
  assign in_ready  = !s1_full | !s2_full | out_ready;
  assign s1_load   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full   <= 1'b0;
      s2_full   <= 1'b0;
      s1_i      <= '0;
      s1_q      <= '0;
      out_i     <= '0;
      out_q     <= '0;
      out_label <= '0;
    end else begin
      if (s1_load) begin
        s1_full <= 1'b1;
        s1_i    <= dec_i;
        s1_q    <= dec_q;
      end else if (s2_load) begin
        s1_full <= 1'b0;
      end
      if (s2_load) begin
        s2_full   <= 1'b1;
        out_i     <= level(s1_i);
        out_q     <= level(s1_q);
        out_label <= {gray(s1_i), gray(s1_q)};
      end else if (out_ready) begin
        s2_full <= 1'b0;
      end
    end
  end

  // Clear wins over the increment of the same cycle; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      clip_cnt <= '0;
    end else if (s1_load) begin
      clip_cnt <= clip_sum[CNT_W] ? '1 : clip_sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_qam_slicer.sv
`timescale 1ns/1ps
// tb_qam_slicer: four slicer configurations driven in lockstep and checked every cycle
// against a real-arithmetic model of the slicing, labelling and clip rules.
module tb_qam_slicer;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, cnt_clr;
  logic [31:0] in_i, in_q;

  logic        ir3, ov3, ir1, ov1, ir4, ov4, irc, ovc;
  logic [31:0] oi3, oq3, oi1, oq1, oi4, oq4, oic, oqc;
  logic [5:0]  lab3, labc;
  logic [1:0]  lab1;
  logic [7:0]  lab4;
  logic [15:0] cc3, cc1, cc4;
  logic [1:0]  ccc;

  qam_slicer #(.B(3), .CNT_W(16)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3),
    .in_i(in_i), .in_q(in_q), .out_valid(ov3), .out_ready(out_ready), .out_i(oi3), .out_q(oq3),
    .out_label(lab3), .clip_cnt(cc3), .cnt_clr(cnt_clr));
  qam_slicer #(.B(1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .in_i(in_i), .in_q(in_q), .out_valid(ov1), .out_ready(out_ready), .out_i(oi1), .out_q(oq1),
    .out_label(lab1), .clip_cnt(cc1), .cnt_clr(cnt_clr));
  qam_slicer #(.B(4), .CNT_W(16)) u4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
    .in_i(in_i), .in_q(in_q), .out_valid(ov4), .out_ready(out_ready), .out_i(oi4), .out_q(oq4),
    .out_label(lab4), .clip_cnt(cc4), .cnt_clr(cnt_clr));
  qam_slicer #(.B(3), .CNT_W(2)) uc (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irc),
    .in_i(in_i), .in_q(in_q), .out_valid(ovc), .out_ready(out_ready), .out_i(oic), .out_q(oqc),
    .out_label(labc), .clip_cnt(ccc), .cnt_clr(cnt_clr));

  logic        ir_a[4], ov_a[4];
  logic [31:0] oi_a[4], oq_a[4];
  logic [7:0]  lab_a[4];
  logic [15:0] cc_a[4];

  always_comb begin
    ir_a[0] = ir3; ir_a[1] = ir1; ir_a[2] = ir4; ir_a[3] = irc;
    ov_a[0] = ov3; ov_a[1] = ov1; ov_a[2] = ov4; ov_a[3] = ovc;
    oi_a[0] = oi3; oi_a[1] = oi1; oi_a[2] = oi4; oi_a[3] = oic;
    oq_a[0] = oq3; oq_a[1] = oq1; oq_a[2] = oq4; oq_a[3] = oqc;
    lab_a[0] = {2'b0, lab3}; lab_a[1] = {6'b0, lab1}; lab_a[2] = lab4; lab_a[3] = {2'b0, labc};
    cc_a[0] = cc3; cc_a[1] = cc1; cc_a[2] = cc4; cc_a[3] = {14'b0, ccc};
  end

  // ---------------- checking helpers ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] lvl;
    logic [3:0]  lab;
    logic        clip;
  } mcomp_t;

  function automatic mcomp_t model_comp(input logic [31:0] x, input int b);
    mcomp_t      r;
    int          kmax, k, lv, n;
    real         a, half;
    logic [63:0] d;
    logic [7:0]  e;
    e    = x[30:23];
    kmax = (1 << (b - 1)) - 1;
    if (e == 8'd0)        a = 0.0;
    else if (e == 8'd255) a = 1.0e300;
    else                  a = $bitstoreal({1'b0, 11'(int'(e) + 896), x[22:0], 29'd0});
    half = a / 2.0;
    if (half >= real'(kmax)) k = kmax;
    else                     k = $rtoi(half);
    lv     = 2 * k + 1;
    d      = $realtobits(real'(lv));
    r.lvl  = {x[31], 8'(int'(d[62:52]) - 896), d[51:29]};
    n      = x[31] ? (kmax - k) : (kmax + 1 + k);
    r.lab  = 4'(n ^ (n >> 1));
    r.clip = (e == 8'd255) || (a >= real'(1 << b));
    return r;
  endfunction

  typedef struct packed {
    logic [3:0][31:0] oi;
    logic [3:0][31:0] oq;
    logic [3:0][7:0]  lab;
  } exp_t;

  exp_t   exp_q[$];
  int     tag_q[$];
  int     bval[4] = '{3, 1, 4, 3};
  int     cmax[4] = '{65535, 65535, 65535, 3};
  int     mcnt[4] = '{0, 0, 0, 0};
  int     m_inc[4];
  int     cyc = 0;
  bit     mon_on = 0;
  exp_t   m_e;
  mcomp_t m_ci, m_cq;
  logic   m_ir, m_ov;

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (mon_on) begin
      m_ir = !(exp_q.size() == 2 && !out_ready);
      m_ov = 1'b0;
      if (exp_q.size() > 0) m_ov = (tag_q[0] <= cyc - 2);
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("dut%0d in_ready", n), 32'(ir_a[n]), 32'(m_ir));
        chk($sformatf("dut%0d out_valid", n), 32'(ov_a[n]), 32'(m_ov));
        chk($sformatf("dut%0d clip_cnt", n), 32'(cc_a[n]), 32'(mcnt[n]));
        if (m_ov) begin
          chk($sformatf("dut%0d out_i", n), oi_a[n], exp_q[0].oi[n]);
          chk($sformatf("dut%0d out_q", n), oq_a[n], exp_q[0].oq[n]);
          chk($sformatf("dut%0d out_label", n), 32'(lab_a[n]), 32'(exp_q[0].lab[n]));
        end
      end
      for (int n = 0; n < 4; n++) begin
        m_ci       = model_comp(in_i, bval[n]);
        m_cq       = model_comp(in_q, bval[n]);
        m_e.oi[n]  = m_ci.lvl;
        m_e.oq[n]  = m_cq.lvl;
        m_e.lab[n] = 8'((int'(m_ci.lab) << bval[n]) | int'(m_cq.lab));
        m_inc[n]   = (m_ci.clip ? 1 : 0) + (m_cq.clip ? 1 : 0);
      end
      if (rst) begin
        exp_q.delete();
        tag_q.delete();
        for (int n = 0; n < 4; n++) mcnt[n] = 0;
      end else begin
        if (m_ov && out_ready) begin
          void'(exp_q.pop_front());
          void'(tag_q.pop_front());
        end
        for (int n = 0; n < 4; n++) begin
          if (cnt_clr) mcnt[n] = 0;
          else if (in_valid && m_ir) mcnt[n] = (mcnt[n] + m_inc[n] > cmax[n]) ? cmax[n] : mcnt[n] + m_inc[n];
        end
        if (in_valid && m_ir) begin
          exp_q.push_back(m_e);
          tag_q.push_back(cyc);
        end
      end
    end
    cyc++;
  end

  // ---------------- out_ready pattern generator ----------------
  int         bp_mode = 0;
  int         ph = 0;
  logic [3:0] pat = 4'b1001;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ph++;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[ph % 4];
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] q);
    bit ok = 0;
    int w  = 0;
    in_valid = 1'b1;
    in_i     = i;
    in_q     = q;
    while (!ok) begin
      @(negedge clk);
      ok = ir3;
      sync();
      w++;
      if (!ok && w > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: pair %h/%h not accepted after %0d cycles", i, q, w);
        return;
      end
    end
  endtask

  task automatic drain();
    int w = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && w < 200) begin
      sync();
      w++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pairs outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic pin(input logic [31:0] x, input int b, input logic [31:0] lvl,
                     input logic [3:0] lab, input logic clip);
    mcomp_t r;
    r = model_comp(x, b);
    chk($sformatf("model lvl %h b%0d", x, b), r.lvl, lvl);
    chk($sformatf("model lab %h b%0d", x, b), 32'(r.lab), 32'(lab));
    chk($sformatf("model clip %h b%0d", x, b), 32'(r.clip), 32'(clip));
  endtask

  function automatic logic [31:0] rand_f32();
    int         sel;
    logic [7:0] e;
    logic [31:0] m;
    sel = $urandom_range(0, 9);
    m   = $urandom;
    if (sel == 0)      e = 8'd0;
    else if (sel == 1) e = 8'd255;
    else               e = 8'($urandom_range(118, 133));
    return {1'($urandom_range(0, 1)), e, m[22:0]};
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_i = '0; in_q = '0; cnt_clr = 1'b0;

    // hand-computed pins of the model
    pin(32'h40200000, 3, 32'h40400000, 4'b0111, 1'b0);
    pin(32'hC0E00000, 3, 32'hC0E00000, 4'b0000, 1'b0);
    pin(32'h40000000, 3, 32'h40400000, 4'b0111, 1'b0);
    pin(32'h3FFFFFFF, 3, 32'h3F800000, 4'b0110, 1'b0);
    pin(32'h40800000, 3, 32'h40A00000, 4'b0101, 1'b0);
    pin(32'h80000000, 3, 32'hBF800000, 4'b0010, 1'b0);
    pin(32'h42C80000, 3, 32'h40E00000, 4'b0100, 1'b1);
    pin(32'h7FC00000, 3, 32'h40E00000, 4'b0100, 1'b1);
    pin(32'h40C00000, 3, 32'h40E00000, 4'b0100, 1'b0);
    pin(32'h412E6666, 4, 32'h41300000, 4'b1011, 1'b0);
    pin(32'h41A00000, 4, 32'h41700000, 4'b1000, 1'b1);
    pin(32'h40200000, 1, 32'h3F800000, 4'b0001, 1'b1);
    pin(32'hC0E00000, 1, 32'hBF800000, 4'b0000, 1'b1);
    pin(32'h3F000000, 1, 32'h3F800000, 4'b0001, 1'b0);

    repeat (3) sync();
    rst    = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    chk("reset out_i", oi3, 32'h0);
    chk("reset out_q", oq3, 32'h0);
    chk("reset out_label", 32'(lab3), 32'h0);
    chk("reset clip_cnt", 32'(cc3), 32'h0);
    chk("reset in_ready", 32'(ir3), 32'h1);
    chk("reset out_valid", 32'(ov3), 32'h0);
    sync();

    // first pair and latency
    send(32'h40200000, 32'hC0E00000);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat1 out_valid", 32'(ov3), 32'h0);
    @(negedge clk);
    chk("lat2 out_valid", 32'(ov3), 32'h1);
    chk("lat2 out_i", oi3, 32'h40400000);
    chk("lat2 out_q", oq3, 32'hC0E00000);
    chk("lat2 out_label", 32'(lab3), 32'(6'b111000));
    sync();

    // decision boundaries and negative zero
    send(32'h40000000, 32'h3FFFFFFF);
    send(32'h40800000, 32'h80000000);
    drain();

    // clipping and clear
    send(32'h42C80000, 32'h7FC00000);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clip two", 32'(cc3), 32'd2);
    sync();
    send(32'h40C00000, 32'h00000000);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clip none", 32'(cc3), 32'd2);
    sync();
    cnt_clr = 1'b1;
    sync();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clear b3", 32'(cc3), 32'd0);
    chk("clear cnt2", 32'(ccc), 32'd0);
    sync();

    // saturation of the narrow counter
    repeat (5) send(32'h42C80000, 32'hC2C80000);
    in_valid = 1'b0;
    @(negedge clk);
    chk("sat cnt2", 32'(ccc), 32'd3);
    chk("sat b3", 32'(cc3), 32'd10);
    sync();
    drain();

    // wider constellation values
    send(32'h412E6666, 32'h41A00000);
    send(32'hC12E6666, 32'h00000001);
    drain();

    // backpressure with random pairs
    bp_mode = 1;
    for (int t = 0; t < 10; t++) send(rand_f32(), rand_f32());
    drain();
    bp_mode = 0;

    // reset with two pairs in flight
    bp_mode = 2;
    sync();
    send(32'h42C80000, 32'h40400000);
    send(32'h7FC00000, 32'h3F800000);
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall in_ready", 32'(ir3), 32'h0);
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst out_valid", 32'(ov3), 32'h0);
    chk("midrst clip_cnt", 32'(cc3), 32'h0);
    chk("midrst in_ready", 32'(ir3), 32'h1);
    sync();
    bp_mode = 0;
    sync();
    send(32'h40200000, 32'hC0E00000);
    in_valid = 1'b0;
    @(negedge clk);
    chk("post lat1 out_valid", 32'(ov3), 32'h0);
    @(negedge clk);
    chk("post lat2 out_valid", 32'(ov3), 32'h1);
    chk("post lat2 out_i", oi3, 32'h40400000);
    sync();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
